// File: rtl/svga_vram_arbiter_if.sv
// Bundle of the display read port, CPU framebuffer port and block-RAM port
// that connect to the SVGA VRAM arbiter.
`timescale 1ns/1ps

interface svga_vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();
    // Display read port
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;

    // CPU framebuffer port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    // Single-port block RAM, 1-cycle read latency
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Status
    logic              wbuf_empty;

    // Arbiter side
    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output disp_rdata, disp_rvalid, cpu_ack, cpu_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata, wbuf_empty
    );

    // Environment side: SVGA controller, CPU bus decoder and RAM
    modport master (
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  disp_rdata, disp_rvalid, cpu_ack, cpu_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata, wbuf_empty
    );
endinterface

// File: rtl/svga_vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win and have a fixed 3-cycle
// latency; CPU writes are posted into a small FIFO and drained in free RAM
// cycles; CPU reads wait for the FIFO to empty so they observe earlier writes.
`timescale 1ns/1ps

module svga_vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int WBUF_DEPTH = 4
) (
    input  logic               sys_clk,
    input  logic               reset_n,
    svga_vram_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_RD_WAIT = 2'd1;
    localparam logic [1:0] C_RD_PEND = 2'd2;
    localparam logic [1:0] C_ACK     = 2'd3;

    logic [1:0]        state_q, state_d;

    // Write buffer: pointers carry one extra wrap bit to tell full from empty
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0]  wr_idx, rd_idx;
    logic [ADDR_W-1:0] wbuf_addr_q [WBUF_DEPTH];
    logic [DATA_W-1:0] wbuf_data_q [WBUF_DEPTH];
    logic              wbuf_full_w, wbuf_empty_w;
    logic              push, drain, rd_issue;

    // Registered RAM command
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    // Read-return tracking: [0] = command on RAM pins, [1] = RAM data valid
    logic [1:0]        disp_pipe_q, cpu_pipe_q;
    logic              disp_rvalid_q;
    logic [DATA_W-1:0] disp_rdata_q;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    assign wr_idx       = wr_ptr_q[PTR_W-1:0];
    assign rd_idx       = rd_ptr_q[PTR_W-1:0];
    assign wbuf_empty_w = (wr_ptr_q == rd_ptr_q);
    assign wbuf_full_w  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                          (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Per-cycle grant: display, then pending CPU read, then buffer drain
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the if/case leaves it unassigned and no latch appears.
        rd_issue    = (state_q == C_RD_WAIT) && wbuf_empty_w && !bus.disp_req;
        drain       = !bus.disp_req && !rd_issue && !wbuf_empty_w;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        if (bus.disp_req) begin
            ram_en_d   = 1'b1;
            ram_addr_d = bus.disp_addr;
        end else if (rd_issue) begin
            ram_en_d   = 1'b1;
            ram_addr_d = bus.cpu_addr;
        end else if (drain) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = wbuf_addr_q[rd_idx];
            ram_wdata_d = wbuf_data_q[rd_idx];
        end
    end

    // CPU port FSM: posts writes, sequences reads behind the write buffer
    always_comb begin
        state_d     = state_q;
        push        = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            C_IDLE: begin
                if (bus.cpu_req) begin
                    if (bus.cpu_we) begin
                        // A full buffer still accepts when its head leaves this cycle
                        if (!wbuf_full_w || drain) begin
                            push    = 1'b1;
                            state_d = C_ACK;
                        end
                    end else begin
                        state_d = C_RD_WAIT;
                    end
                end
            end
            C_RD_WAIT: begin
                if (rd_issue) begin
                    state_d = C_RD_PEND;
                end
            end
            C_RD_PEND: begin
                if (cpu_pipe_q[1]) begin
                    cpu_rdata_d = bus.ram_rdata;
                    state_d     = C_ACK;
                end
            end
            C_ACK: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // FSM state and buffer pointers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        // NOTE: registers use <= so every flop samples pre-edge values together.
        if (!reset_n) begin
            state_q  <= C_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (drain) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Buffer storage, written on accepted CPU writes
    always_ff @(posedge sys_clk) begin
        // NOTE: storage has no reset; the pointers alone decide which entries are live.
        if (push) begin
            wbuf_addr_q[wr_idx] <= bus.cpu_addr;
            wbuf_data_q[wr_idx] <= bus.cpu_wdata;
        end
    end

    // Registered RAM command
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Read-return pipelines and captured read data
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_pipe_q   <= '0;
            cpu_pipe_q    <= '0;
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            cpu_rdata_q   <= '0;
        end else begin
            disp_pipe_q   <= {disp_pipe_q[0], bus.disp_req};
            cpu_pipe_q    <= {cpu_pipe_q[0], rd_issue};
            disp_rvalid_q <= disp_pipe_q[1];
            if (disp_pipe_q[1]) begin
                disp_rdata_q <= bus.ram_rdata;
            end
            cpu_rdata_q   <= cpu_rdata_d;
        end
    end

    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.disp_rdata  = disp_rdata_q;
    assign bus.cpu_ack     = (state_q == C_ACK);
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.wbuf_empty  = wbuf_empty_w;

endmodule

// File: tb/tb_svga_vram_arbiter.sv
// Bench for svga_vram_arbiter: a cycle table for basic display/CPU timing,
// then directed sequences for streaming, buffering, ordering and reset.
`timescale 1ns/1ps

module tb_svga_vram_arbiter;

    logic sys_clk;
    logic reset_n;

    svga_vram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    svga_vram_arbiter #(.ADDR_W(16), .DATA_W(8), .WBUF_DEPTH(4)) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // RAM model: unwritten words read back as their low address byte
    logic [7:0]  mem     [65536];
    bit          written [65536];
    int          cyc;
    logic [15:0] wlog_addr [$];
    logic [7:0]  wlog_data [$];
    int          wlog_cyc  [$];
    int          rlog200_cyc [$];

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr]     <= bus.ram_wdata;
                written[bus.ram_addr] <= 1'b1;
                wlog_addr.push_back(bus.ram_addr);
                wlog_data.push_back(bus.ram_wdata);
                wlog_cyc.push_back(cyc);
            end else begin
                bus.ram_rdata <= written[bus.ram_addr] ? mem[bus.ram_addr] : bus.ram_addr[7:0];
                if (bus.ram_addr == 16'h0200) begin
                    rlog200_cyc.push_back(cyc);
                end
            end
        end
    end

    int total;
    int bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int budget,
                             output bit acked);
        acked         = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        for (int n = 0; n < budget; n++) begin
            @(negedge sys_clk);
            if (bus.cpu_ack) begin
                acked = 1'b1;
                break;
            end
        end
        if (acked) bus.cpu_req = 1'b0;
    endtask

    // One cycle: outputs expected in this cycle, then inputs applied for it
    typedef struct {
        logic        dreq;
        logic [15:0] daddr;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [7:0]  cwdata;
        logic        en;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        ack;
        logic        dv;
        logic [7:0]  dd;
        logic [7:0]  crd;
        logic        empty;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          acked;
        bit          got;
        logic [7:0]  data;
        logic [7:0]  e;
        int          base, rbase, stream_bad, stream_we, dv_seen, w_c;

        total = 0;
        bad   = 0;

        //           dreq daddr   creq cwe caddr   cwdata | en  we  addr    wdata  ack dv  dd     crd    empty
        vecs[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 16'h0011, 1'b1, 1'b1, 16'h1000, 8'hA0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0011, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1000, 8'h00, 1'b1, 1'b1, 16'h1000, 8'hA0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 8'h11, 8'h00, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1000, 8'h00, 1'b1, 1'b0, 16'h1000, 8'h00, 1'b0, 1'b0, 8'h11, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h11, 8'h00, 1'b1};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h11, 8'hA0, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h11, 8'hA0, 1'b1};
        vecs[9]  = '{1'b1, 16'h0020, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h11, 8'hA0, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 1'b0, 8'h11, 8'hA0, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b0, 1'b0, 8'h11, 8'hA0, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 8'h20, 8'hA0, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h20, 8'h05, 1'b1};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h20, 8'h05, 1'b1};

        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        reset_n       = 1'b0;

        // Outputs while held in reset
        repeat (3) @(negedge sys_clk);
        check("rst0_ram_en", bus.ram_en, 0);
        check("rst0_cpu_ack", bus.cpu_ack, 0);
        check("rst0_disp_rvalid", bus.disp_rvalid, 0);
        check("rst0_wbuf_empty", bus.wbuf_empty, 1);
        reset_n = 1'b1;

        // Cycle table: display latency, posted write, read, read delayed by display
        for (int i = 0; i < 15; i++) begin
            @(negedge sys_clk);
            check($sformatf("v%0d_ram_en", i), bus.ram_en, vecs[i].en);
            check($sformatf("v%0d_ram_we", i), bus.ram_we, vecs[i].we);
            check($sformatf("v%0d_ram_addr", i), bus.ram_addr, vecs[i].addr);
            check($sformatf("v%0d_ram_wdata", i), bus.ram_wdata, vecs[i].wdata);
            check($sformatf("v%0d_cpu_ack", i), bus.cpu_ack, vecs[i].ack);
            check($sformatf("v%0d_disp_rvalid", i), bus.disp_rvalid, vecs[i].dv);
            check($sformatf("v%0d_disp_rdata", i), bus.disp_rdata, vecs[i].dd);
            check($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata, vecs[i].crd);
            check($sformatf("v%0d_wbuf_empty", i), bus.wbuf_empty, vecs[i].empty);
            bus.disp_req  = vecs[i].dreq;
            bus.disp_addr = vecs[i].daddr;
            bus.cpu_req   = vecs[i].creq;
            bus.cpu_we    = vecs[i].cwe;
            bus.cpu_addr  = vecs[i].caddr;
            bus.cpu_wdata = vecs[i].cwdata;
        end

        // Display stream: 800 back-to-back reads, data returns 3 cycles later
        stream_bad = 0;
        stream_we  = 0;
        for (int i = 0; i < 804; i++) begin
            @(negedge sys_clk);
            e = 8'(i - 3);
            if ((i >= 3) && (i < 803)) begin
                if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== e) stream_bad++;
            end else if (bus.disp_rvalid !== 1'b0) begin
                stream_bad++;
            end
            if (bus.ram_we) stream_we++;
            bus.disp_req  = (i < 800);
            bus.disp_addr = 16'(i);
        end
        check("stream_bad_cycles", stream_bad, 0);
        check("stream_ram_we", stream_we, 0);

        // Write buffering under continuous display load
        base          = wlog_addr.size();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            cpu_write(16'h0100 + 16'(i), 8'hA0 + 8'(i), 4, acked);
            check($sformatf("wb_ack%0d", i), acked, 1);
        end
        check("wb_not_empty", bus.wbuf_empty, 0);
        cpu_write(16'h0104, 8'hA4, 6, acked);
        check("wb_5th_held", acked, 0);
        check("wb_no_write_under_disp", wlog_addr.size() - base, 0);
        bus.disp_req = 1'b0;
        @(negedge sys_clk);
        check("wb_5th_ack", bus.cpu_ack, 1);
        bus.cpu_req = 1'b0;
        check("wb_occ_c1", bus.wbuf_empty, 0);
        for (int j = 2; j < 5; j++) begin
            @(negedge sys_clk);
            check($sformatf("wb_occ_c%0d", j), bus.wbuf_empty, 0);
        end
        @(negedge sys_clk);
        check("wb_drained", bus.wbuf_empty, 1);
        repeat (2) @(negedge sys_clk);
        check("wb_write_count", wlog_addr.size() - base, 5);
        for (int k = 0; k < 5; k++) begin
            if (base + k < wlog_addr.size()) begin
                check($sformatf("wb_order_addr%0d", k), wlog_addr[base + k], 16'h0100 + 16'(k));
                check($sformatf("wb_order_data%0d", k), wlog_data[base + k], 8'hA0 + 8'(k));
            end
        end

        // Read-after-write: the read waits until the posted write reaches RAM
        base          = wlog_addr.size();
        rbase         = rlog200_cyc.size();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 16'h0300;
        cpu_write(16'h0200, 8'h55, 4, acked);
        check("raw_wr_ack", acked, 1);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h0200;
        repeat (3) @(negedge sys_clk);
        check("raw_buffer_held", bus.wbuf_empty, 0);
        check("raw_no_early_read", rlog200_cyc.size() - rbase, 0);
        bus.disp_req = 1'b0;
        got  = 1'b0;
        data = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge sys_clk);
            if (bus.cpu_ack) begin
                got  = 1'b1;
                data = bus.cpu_rdata;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        check("raw_rd_ack", got, 1);
        check("raw_rdata", data, 8'h55);
        w_c = -1;
        for (int k = base; k < wlog_addr.size(); k++) begin
            if (wlog_addr[k] == 16'h0200) w_c = wlog_cyc[k];
        end
        check("raw_write_seen", (w_c >= 0), 1);
        check("raw_read_after_write", (rlog200_cyc.size() > rbase) && (rlog200_cyc[rbase] > w_c), 1);

        // Asynchronous reset with three entries buffered and display reads in flight
        base          = wlog_addr.size();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 16'h0310;
        for (int i = 0; i < 3; i++) begin
            cpu_write(16'h0400 + 16'(i), 8'h11 * 8'(i + 1), 4, acked);
            check($sformatf("rst_wr_ack%0d", i), acked, 1);
        end
        check("rst_pre_not_empty", bus.wbuf_empty, 0);
        check("rst_pre_no_write", wlog_addr.size() - base, 0);
        @(posedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_disp_rvalid", bus.disp_rvalid, 0);
        check("rst_disp_rdata", bus.disp_rdata, 0);
        check("rst_cpu_ack", bus.cpu_ack, 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_wbuf_empty", bus.wbuf_empty, 1);
        @(negedge sys_clk);
        bus.disp_req = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        base    = wlog_addr.size();
        dv_seen = 0;
        repeat (8) begin
            @(negedge sys_clk);
            if (bus.disp_rvalid) dv_seen++;
        end
        check("rst_no_write_after", wlog_addr.size() - base, 0);
        check("rst_no_rvalid_after", dv_seen, 0);
        check("rst_empty_after", bus.wbuf_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
